spmv_feeder: RTL
================

# spmv_feeder

- Sequencer that drives one `SpMV_core` through a full sparse matrix–vector product.
- Stores one 16x16 CSR matrix (values, column indices, row pointers) and a 16-entry fp16 input vector, all loaded by the host.
- Starts the core, streams one nonzero per core MUL→ADD→WRITE pass, and captures the 16 result registers when the core reports DONE.
- Sits between the host register interface and `SpMV_core`, which it drives.

## Interface

Parameters:
- `NNZ_MAX`, 64: value/column storage depth (maximum nonzeros).

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_wr_en`  in  1  host write strobe.
- `i_wr_sel`  in  2  write target: 0 = value+column entry, 1 = vector entry, 2 = row pointer, 3 = ignored.
- `i_wr_addr`  in  8  entry index.
- `i_wr_data`  in  16  fp16 value, vector element, or row pointer (row pointer uses bits [7:0]).
- `i_wr_col`  in  4  column index; used only when sel = 0.
- `i_go`  in  1  start request.
- `o_busy`  out  1  high from accepted go until done pulse.
- `o_done`  out  1  one-cycle completion pulse.
- `o_overrun`  out  1  sticky error; cleared by next accepted go.
- `o_result`  out  256  captured core registers; row r in [16r+15:16r].
- `o_start`  out  1  to core start input.
- `o_mat_value`  out  16  to core matrix-value input.
- `o_in_vector`  out  16  to core vector input.
- `o_count`  out  8  to core nonzero index.
- `o_row_ptr`  out  136  to core row pointers; entry i in [8i+7:8i].
- `i_core_state`  in  3  core state: 0 IDLE, 1 MUL, 2 ADD, 3 WRITE, 4 DONE.
- `i_core_register`  in  256  core result bus.

## Operation

- FSM states: IDLE, START, RUN, CAPTURE.
- Host writes:
  - Accepted only in IDLE; dropped silently otherwise.
  - sel 0: addr ≥ NNZ_MAX dropped. sel 1: addr ≥ 16 dropped. sel 2: addr ≥ 17 dropped.
- `nnz` = row_ptr[16].
- IDLE + `i_go`:
  - Clear `o_overrun`, set k = 0.
  - nnz = 0: skip the core, clear `o_result` to 0, pulse `o_done` next cycle, stay IDLE.
  - Otherwise go to START.
- START:
  - Drive `o_start` = 1 for exactly this one cycle.
  - Move to RUN unconditionally.
- RUN:
  - `o_count` = k; `o_mat_value` = value[k]; `o_in_vector` = vec[col[k]].
  - These three stay stable from START through each WRITE.
  - In every cycle with `i_core_state` = WRITE:
    - k ← k+1.
    - All three outputs reload for k+1 at that same edge, so they are valid when the core re-enters MUL.
  - For k ≥ nnz, `o_mat_value` and `o_in_vector` are 0 (zero contribution).
  - If k would reach NNZ_MAX: hold k at NNZ_MAX−1 and set `o_overrun`.
  - `i_core_state` = DONE → CAPTURE.
- CAPTURE:
  - `o_result` ← `i_core_register`.
  - `o_done` = 1 for one cycle, `o_busy` drops, return to IDLE.
- `o_row_ptr` always reflects stored row pointers (combinational from storage).
- `i_go` while busy is ignored.
- Simultaneous `i_go` and `i_wr_en` in IDLE: the write completes first, so a write to row_ptr[16] affects that run's nnz.

## Timing

- Reset values:
  - All storage = 0, k = 0, state IDLE.
  - `o_start`, `o_done`, `o_busy`, `o_overrun` = 0.
  - `o_result`, `o_mat_value`, `o_in_vector`, `o_count` = 0.
- `o_busy` rises the cycle after accepted go.
- `o_start` is high the cycle after go; the core is in MUL the cycle after that.
- Per nonzero: 3 cycles (MUL, ADD, WRITE).
- Total latency from go to `o_done`, nnz > 0: 1 + 1 + 3·nnz + 1 (DONE) + 1 (CAPTURE).
- nnz = 0: `o_done` one cycle after go, `o_busy` never rises.
- Reset asserted mid-run:
  - Everything returns to reset values immediately.
  - `o_done` is not produced.
  - Stored matrix is lost.

## Test plan

- Reset, then sample: all outputs 0, state IDLE; go with empty storage → `o_done` one cycle later, `o_result` = 0.
- Identity-diagonal load: values 0x3C00 (1.0) at (i,i), row_ptr 0..16, vec[i] = i as fp16. Go → `o_count` steps 0..15, one step per WRITE; `o_result` row i = vec[i]; `o_done` at go+52.
- Row 3 holds two nonzeros 0x4000 (2.0) at columns 1 and 5, vec[1] = vec[5] = 0x3C00, other rows empty. Go → `o_result` row 3 = 0x4400 (4.0), all other rows 0.
- Host writes issued during RUN (sel 0, addr 0) → storage unchanged after `o_done`; a second go reproduces an identical `o_result`.
- Core model stays in MUL/ADD/WRITE beyond nnz until k saturates at NNZ_MAX−1 → `o_overrun` = 1 and sticky, streamed value/vector read 0; next go clears it.
- Reset asserted mid-RUN at nonzero 5 → `o_busy` = 0, `o_start` = 0, `o_count` = 0 in the same cycle; no `o_done` follows.

Source files
------------

// File: rtl/spmv_feeder.sv
// spmv_feeder: sequencer that walks one SpMV_core through a full sparse matrix-vector product.
//
// Holds one 16x16 CSR matrix (values, column indices, row pointers) plus a 16-entry fp16 input
// vector, all written by the host while idle. On go it pulses the core start, streams one
// nonzero per core MUL->ADD->WRITE pass, and latches the core's 16 result registers when the
// core reports DONE.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_wr_en/_sel/_addr/     host write: sel 0 value+column, 1 vector, 2 row pointer, 3 ignored
//   i_wr_data/_col
//   i_go                    start request (ignored while busy)
//   o_busy, o_done          run in progress / one-cycle completion pulse
//   o_overrun               sticky: nonzero index saturated at NNZ_MAX-1
//   o_result                captured core registers, row r in [16r+15:16r]
//   o_start, o_mat_value,   drive the core: start pulse, streamed value, vector element,
//   o_in_vector, o_count,   nonzero index, and row pointers (entry i in [8i+7:8i])
//   o_row_ptr
//   i_core_state            core state: 0 IDLE, 1 MUL, 2 ADD, 3 WRITE, 4 DONE
//   i_core_register         core result bus

module spmv_feeder #(
   parameter int unsigned NNZ_MAX = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_wr_en,
   input  logic [1:0]   i_wr_sel,
   input  logic [7:0]   i_wr_addr,
   input  logic [15:0]  i_wr_data,
   input  logic [3:0]   i_wr_col,
   input  logic         i_go,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_overrun,
   output logic [255:0] o_result,
   output logic         o_start,
   output logic [15:0]  o_mat_value,
   output logic [15:0]  o_in_vector,
   output logic [7:0]   o_count,
   output logic [135:0] o_row_ptr,
   input  logic [2:0]   i_core_state,
   input  logic [255:0] i_core_register
);

   localparam int unsigned AW     = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;
   localparam logic [7:0]  KLast  = 8'(NNZ_MAX - 1);
   localparam logic [8:0]  NnzLim = 9'(NNZ_MAX);

   localparam logic [2:0] CoreWrite = 3'd3;
   localparam logic [2:0] CoreDone  = 3'd4;

   typedef enum logic [1:0] {StIdle, StStart, StRun, StCapture} state_e;

   state_e         state_q, state_d;
   logic [7:0]     k_q, k_d;
   logic           overrun_q, overrun_d;
   logic           done_q, done_d;
   logic [255:0]   result_q, result_d;

   // Matrix and vector storage.
   logic [15:0]    val_q [NNZ_MAX];
   logic [3:0]     col_q [NNZ_MAX];
   logic [15:0]    vec_q [16];
   logic [7:0]     rp_q  [17];

   logic           wr_idle;
   logic           wr_val;
   logic           wr_vec;
   logic           wr_rp;
   logic [7:0]     nnz_eff;
   logic [AW-1:0]  k_idx;
   logic           k_in_range;

   // ---------------------------------------------------------------------------------------------
   // Host write decode: only while idle, out-of-range addresses dropped.
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      wr_idle = i_wr_en && (state_q == StIdle);
      wr_val  = wr_idle && (i_wr_sel == 2'd0) && ({1'b0, i_wr_addr} < NnzLim);
      wr_vec  = wr_idle && (i_wr_sel == 2'd1) && (i_wr_addr < 8'd16);
      wr_rp   = wr_idle && (i_wr_sel == 2'd2) && (i_wr_addr < 8'd17);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(NNZ_MAX); i++) begin
            val_q[i] <= '0;
            col_q[i] <= '0;
         end
         for (int i = 0; i < 16; i++) begin
            vec_q[i] <= '0;
         end
         for (int i = 0; i < 17; i++) begin
            rp_q[i] <= '0;
         end
      end else begin
         if (wr_val) begin
            val_q[i_wr_addr[AW-1:0]] <= i_wr_data;
            col_q[i_wr_addr[AW-1:0]] <= i_wr_col;
         end
         if (wr_vec) begin
            vec_q[i_wr_addr[3:0]] <= i_wr_data;
         end
         if (wr_rp) begin
            rp_q[i_wr_addr[4:0]] <= i_wr_data[7:0];
         end
      end
   end

   for (genvar gi = 0; gi < 17; gi++) begin : g_row_ptr
      assign o_row_ptr[8*gi +: 8] = rp_q[gi];
   end

   // A write to row_ptr[16] in the same cycle as go defines that run's nnz.
   assign nnz_eff = (wr_rp && (i_wr_addr[4:0] == 5'd16)) ? i_wr_data[7:0] : rp_q[16];

   // ---------------------------------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         k_q       <= '0;
         overrun_q <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         overrun_q <= overrun_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      overrun_d = overrun_q;
      done_d    = 1'b0;
      result_d  = result_q;

      case (state_q)
         StIdle: begin
            if (i_go) begin
               overrun_d = 1'b0;
               k_d       = '0;
               if (nnz_eff == 8'd0) begin
                  // Empty matrix: no core pass, report an all-zero result right away.
                  result_d = '0;
                  done_d   = 1'b1;
               end else begin
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            state_d = StRun;
         end
         StRun: begin
            if (i_core_state == CoreWrite) begin
               // Advancing on WRITE makes the next operands valid when the core re-enters MUL.
               if (k_q == KLast) begin
                  overrun_d = 1'b1;
               end else begin
                  k_d = k_q + 8'd1;
               end
            end else if (i_core_state == CoreDone) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            result_d = i_core_register;
            done_d   = 1'b1;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // Core-facing operand stream: read straight from storage at index k, so a reload of k at the
   // WRITE edge updates all three outputs together.
   // ---------------------------------------------------------------------------------------------
   assign k_idx      = k_q[AW-1:0];
   assign k_in_range = (k_q < rp_q[16]);

   always_comb begin
      o_busy      = (state_q != StIdle);
      o_start     = (state_q == StStart);
      o_count     = k_q;
      o_mat_value = '0;
      o_in_vector = '0;
      // Indices past nnz stream zeros so extra core passes contribute nothing.
      if ((state_q != StIdle) && k_in_range) begin
         o_mat_value = val_q[k_idx];
         o_in_vector = vec_q[col_q[k_idx]];
      end
   end

   assign o_done    = done_q;
   assign o_overrun = overrun_q;
   assign o_result  = result_q;

endmodule
